// File: rtl/pwm_fade.sv
// pwm_fade: triangle fade engine that drives the compare value of a pwm
// instance. The level rises by step_i per tick to full scale, dwells,
// falls back to zero, dwells, and repeats. A tick is one out of every
// prescale_i+1 period_start_i pulses.
//
// Optional build macro: PWM_FADE_GAMMA_EN squares the level (upper half
// of the product) before it is registered to cmp_value_o.
//
// Handshake: none. period_start_i is a single-cycle strobe with no ready;
// cycle_o is a single-cycle strobe with no back-pressure.
//
// state_o exposes the FSM state for checkers:
// 0=IDLE 1=RISE 2=HOLD_TOP 3=FALL 4=HOLD_BOTTOM.
module pwm_fade #(
  parameter int COUNTER_WIDTH  = 10,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_i,
  input  logic                      period_start_i,
  input  logic [3:0]                step_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [PRESCALE_WIDTH-1:0] dwell_i,
  output logic [COUNTER_WIDTH-1:0]  cmp_value_o,
  output logic                      rising_o,
  output logic                      cycle_o,
  output logic [2:0]                state_o
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RISE        = 3'd1,
    HOLD_TOP    = 3'd2,
    FALL        = 3'd3,
    HOLD_BOTTOM = 3'd4
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] MAX   = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH:0]   MAX_W = {1'b0, MAX};

  state_t                    state_q, state_d;
  logic [COUNTER_WIDTH-1:0]  level_q, level_d;
  logic [COUNTER_WIDTH-1:0]  cmp_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [PRESCALE_WIDTH-1:0] dwell_q, dwell_d;
  logic                      cycle_d;
  logic                      pulse;
  logic                      tick;

  // One bit of headroom so level+step never wraps before the compare.
  logic [COUNTER_WIDTH:0]    level_w;
  logic [COUNTER_WIDTH:0]    step_w;
  logic [COUNTER_WIDTH:0]    sum_w;

  assign level_w = {1'b0, level_q};
  assign step_w  = {{(COUNTER_WIDTH-3){1'b0}}, step_i};
  assign sum_w   = level_w + step_w;

  // Prescaler: counts enabled period starts outside IDLE; tick on terminal count.
  always_comb begin
    pulse = enable_i && period_start_i && (state_q != IDLE);
    tick  = pulse && (pre_q == prescale_i);
    pre_d = pre_q;
    if (!enable_i) begin
      pre_d = '0;
    end else if (pulse) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  // Next-state, level and dwell logic; disable overrides any tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    dwell_d = dwell_q;
    cycle_d = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      level_d = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          level_d = '0;
          state_d = RISE;
        end
        RISE: begin
          if (tick) begin
            if (sum_w >= MAX_W) begin
              level_d = MAX;
              dwell_d = '0;
              state_d = HOLD_TOP;
            end else begin
              level_d = sum_w[COUNTER_WIDTH-1:0];
            end
          end
        end
        HOLD_TOP: begin
          if (tick) begin
            if (dwell_q == dwell_i) state_d = FALL;
            else                    dwell_d = dwell_q + 1'b1;
          end
        end
        FALL: begin
          if (tick) begin
            if (level_w <= step_w) begin
              level_d = '0;
              dwell_d = '0;
              state_d = HOLD_BOTTOM;
            end else begin
              level_d = level_q - step_w[COUNTER_WIDTH-1:0];
            end
          end
        end
        HOLD_BOTTOM: begin
          if (tick) begin
            if (dwell_q == dwell_i) begin
              state_d = RISE;
              cycle_d = 1'b1;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
          dwell_d = '0;
        end
      endcase
    end
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [2*COUNTER_WIDTH-1:0] square;

  // Perceptual curve: upper half of level squared.
  always_comb begin
    square = level_d * level_d;
    cmp_d  = COUNTER_WIDTH'(square >> COUNTER_WIDTH);
  end
`else
  // Linear output: compare value is the level itself.
  always_comb begin
    cmp_d = level_d;
  end
`endif

  // State, counters and the registered compare value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      pre_q       <= '0;
      dwell_q     <= '0;
      cmp_value_o <= '0;
      cycle_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      pre_q       <= pre_d;
      dwell_q     <= dwell_d;
      cmp_value_o <= cmp_d;
      cycle_o     <= cycle_d;
    end
  end

  assign rising_o = (state_q == RISE) || (state_q == HOLD_TOP);
  assign state_o  = state_q;

endmodule
